id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register directly downstream of reg_file. Captures REGOUT1/REGOUT2, immediate, PC and
//  decoded control each clock, and bypasses same-cycle writeback data (reg_file writes on the edge).
//  Detects load-use hazards, inserts bubbles, and honours branch flush and data-memory busy freeze.
// PARAMETERS
//  DATA_WIDTH      32  width of PC, operands, immediate
//  REG_ADDR_WIDTH  5   register index width
//  ALUOP_WIDTH     3   ALU opcode width
// PORTS
//  CLK             in   1   clock; all state updates on posedge
//  RESET           in   1   asynchronous, active-high reset
//  ID_PC           in   DW  PC of instruction in decode
//  ID_DATA1        in   DW  reg_file REGOUT1 (rs1 value)
//  ID_DATA2        in   DW  reg_file REGOUT2 (rs2 value)
//  ID_IMM          in   DW  sign-extended immediate
//  ID_RS1/ID_RS2   in   RAW source register indices (equal READREG1/READREG2)
//  ID_RD           in   RAW destination index
//  ID_ALUOP        in   AW  ALU opcode
//  ID_WRITEENABLE  in   1   instruction writes rd
//  ID_MEMREAD      in   1   instruction is a load
//  ID_MEMWRITE     in   1   instruction is a store
//  WB_WRITEREG     in   RAW writeback index (same net as reg_file WRITEREG)
//  WB_WRITEDATA    in   DW  writeback data
//  WB_WRITEENABLE  in   1   writeback enable
//  FLUSH           in   1   squash instruction in ID (taken branch/jump)
//  MEM_BUSY        in   1   data memory not ready; freeze this stage
//  EX_PC, EX_DATA1, EX_DATA2, EX_IMM      out DW   registered copies
//  EX_RS1, EX_RS2, EX_RD                  out RAW  registered indices
//  EX_ALUOP                               out AW   registered opcode
//  EX_WRITEENABLE, EX_MEMREAD, EX_MEMWRITE out 1   registered controls
//  HAZARD_STALL    out  1   combinational; hold PC and IF/ID this cycle
// BEHAVIOUR
//  Reset: every EX_* output and flush_pending = 0 immediately on RESET rise; HAZARD_STALL = 0 while RESET.
//  Latency: 1 cycle ID -> EX. Posedge priority: MEM_BUSY > bubble > load.
//  MEM_BUSY=1: all EX_* hold; if FLUSH=1 too, set flush_pending (sticky).
//  Bubble when not busy and (FLUSH | flush_pending | load_use): EX_WRITEENABLE, EX_MEMREAD, EX_MEMWRITE
//   <= 0, EX_RD <= 0, EX_ALUOP <= 0; data fields load normally (don't care); flush_pending <= 0.
//  load_use = EX_MEMREAD & (EX_RD != 0) & ((EX_RD == ID_RS1) | (EX_RD == ID_RS2)).
//  HAZARD_STALL = load_use & ~FLUSH & ~flush_pending & ~MEM_BUSY.
//  After the bubble EX_MEMREAD = 0, so a stall always lasts exactly 1 cycle.
//  Normal load: all EX_* <= ID_* with bypass:
//   EX_DATA1 <= (WB_WRITEENABLE & WB_WRITEREG != 0 & WB_WRITEREG == ID_RS1) ? WB_WRITEDATA : ID_DATA1.
//   EX_DATA2 uses the same rule on ID_RS2. Index 0 is never bypassed.
//  Bypass also applies in bubble cycles (harmless); never applied while MEM_BUSY (hold wins).
//  Reset mid-stall or mid-busy: state cleared; first post-reset edge is a normal load.
// STRUCTURE
//  Shared package cpu_pkg: DATA_WIDTH, REG_ADDR_WIDTH, ALUOP_WIDTH constants, ALUOP encodings,
//   NOP control bundle (all-zero) used for bubbles.
//  Sub-module load_use_detect: combinational compare of EX_RD/EX_MEMREAD against ID_RS1/ID_RS2,
//   outputs load_use. Everything else is inline in this module.
// TESTING
//  1 RESET pulse mid-cycle with EX_* nonzero -> all EX_* = 0 before the next edge; HAZARD_STALL = 0.
//  2 ID_RS1=2, ID_DATA1=0, WB_WRITEREG=2, WB_WRITEDATA=95, WB_WRITEENABLE=1 -> EX_DATA1 = 95 after edge.
//  3 WB_WRITEREG=0, WB_WRITEDATA=28, ID_RS2=0, ID_DATA2=0 -> EX_DATA2 = 0 (no bypass of x0).
//  4 Load rd=4 in EX, ID_RS2=4 -> HAZARD_STALL=1 for 1 cycle; next EX has WRITEENABLE=0, RD=0; then stall=0.
//  5 FLUSH=1 with MEM_BUSY=1 for 3 cycles (FLUSH only first) -> EX holds; first free edge gives bubble.
//  6 Load-use hazard and FLUSH in same cycle -> HAZARD_STALL = 0; bubble inserted; no extra stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants, ALU opcode encodings and the control bundle
// carried through the ID/EX stage.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned ALUOP_WIDTH    = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } aluop_e;

    // Side-effecting controls; all-zero means the instruction does nothing.
    typedef struct packed {
        logic writeenable;
        logic memread;
        logic memwrite;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{writeenable: 1'b0, memread: 1'b0, memwrite: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is a source of the instruction in ID.
module load_use_detect #(
    parameter int unsigned REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH
) (
    input  logic                      ex_memread,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    output logic                      load_use
);

    logic rd_nonzero;
    logic rs_match;

    always_comb begin
        rd_nonzero = (ex_rd != '0);
        rs_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        load_use   = ex_memread && rd_nonzero && rs_match;
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// branch flush (sticky across memory-busy freeze) and memory-busy hold.
module id_ex_pipeline_reg #(
    parameter int unsigned DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
    parameter int unsigned ALUOP_WIDTH    = cpu_pkg::ALUOP_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [DATA_WIDTH-1:0]     ID_PC,
    input  logic [DATA_WIDTH-1:0]     ID_DATA1,
    input  logic [DATA_WIDTH-1:0]     ID_DATA2,
    input  logic [DATA_WIDTH-1:0]     ID_IMM,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RS1,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RS2,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RD,
    input  logic [ALUOP_WIDTH-1:0]    ID_ALUOP,
    input  logic                      ID_WRITEENABLE,
    input  logic                      ID_MEMREAD,
    input  logic                      ID_MEMWRITE,
    input  logic [REG_ADDR_WIDTH-1:0] WB_WRITEREG,
    input  logic [DATA_WIDTH-1:0]     WB_WRITEDATA,
    input  logic                      WB_WRITEENABLE,
    input  logic                      FLUSH,
    input  logic                      MEM_BUSY,
    output logic [DATA_WIDTH-1:0]     EX_PC,
    output logic [DATA_WIDTH-1:0]     EX_DATA1,
    output logic [DATA_WIDTH-1:0]     EX_DATA2,
    output logic [DATA_WIDTH-1:0]     EX_IMM,
    output logic [REG_ADDR_WIDTH-1:0] EX_RS1,
    output logic [REG_ADDR_WIDTH-1:0] EX_RS2,
    output logic [REG_ADDR_WIDTH-1:0] EX_RD,
    output logic [ALUOP_WIDTH-1:0]    EX_ALUOP,
    output logic                      EX_WRITEENABLE,
    output logic                      EX_MEMREAD,
    output logic                      EX_MEMWRITE,
    output logic                      HAZARD_STALL
);

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_NOP = ALUOP_WIDTH'(cpu_pkg::ALU_ADD);

    logic [DATA_WIDTH-1:0]     pc_q,    pc_d;
    logic [DATA_WIDTH-1:0]     data1_q, data1_d;
    logic [DATA_WIDTH-1:0]     data2_q, data2_d;
    logic [DATA_WIDTH-1:0]     imm_q,   imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,   rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,   rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,    rd_d;
    logic [ALUOP_WIDTH-1:0]    aluop_q, aluop_d;
    cpu_pkg::ctrl_t            ctrl_q,  ctrl_d;
    logic                      flush_pending_q, flush_pending_d;

    logic load_use;
    logic bubble;
    logic bypass1;
    logic bypass2;

    load_use_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .ex_memread (ctrl_q.memread),
        .ex_rd      (rd_q),
        .id_rs1     (ID_RS1),
        .id_rs2     (ID_RS2),
        .load_use   (load_use)
    );

    // Next-state: busy holds everything, otherwise load ID with optional bubble.
    always_comb begin
        pc_d            = pc_q;
        data1_d         = data1_q;
        data2_d         = data2_q;
        imm_d           = imm_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        rd_d            = rd_q;
        aluop_d         = aluop_q;
        ctrl_d          = ctrl_q;
        flush_pending_d = flush_pending_q;

        bubble  = FLUSH || flush_pending_q || load_use;
        // reg_file writes on the same edge, so its read ports still show stale data
        bypass1 = WB_WRITEENABLE && (WB_WRITEREG != '0) && (WB_WRITEREG == ID_RS1);
        bypass2 = WB_WRITEENABLE && (WB_WRITEREG != '0) && (WB_WRITEREG == ID_RS2);

        if (MEM_BUSY) begin
            if (FLUSH) begin
                flush_pending_d = 1'b1;
            end
        end else begin
            pc_d            = ID_PC;
            data1_d         = bypass1 ? WB_WRITEDATA : ID_DATA1;
            data2_d         = bypass2 ? WB_WRITEDATA : ID_DATA2;
            imm_d           = ID_IMM;
            rs1_d           = ID_RS1;
            rs2_d           = ID_RS2;
            flush_pending_d = 1'b0;
            if (bubble) begin
                ctrl_d  = cpu_pkg::NOP_CTRL;
                rd_d    = '0;
                aluop_d = ALUOP_NOP;
            end else begin
                ctrl_d.writeenable = ID_WRITEENABLE;
                ctrl_d.memread     = ID_MEMREAD;
                ctrl_d.memwrite    = ID_MEMWRITE;
                rd_d               = ID_RD;
                aluop_d            = ID_ALUOP;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q            <= '0;
            data1_q         <= '0;
            data2_q         <= '0;
            imm_q           <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            aluop_q         <= '0;
            ctrl_q          <= cpu_pkg::NOP_CTRL;
            flush_pending_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            data1_q         <= data1_d;
            data2_q         <= data2_d;
            imm_q           <= imm_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            rd_q            <= rd_d;
            aluop_q         <= aluop_d;
            ctrl_q          <= ctrl_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // A pending or current flush already squashes the dependent instruction.
    always_comb begin
        HAZARD_STALL = !RESET && load_use && !FLUSH && !flush_pending_q && !MEM_BUSY;
    end

    assign EX_PC          = pc_q;
    assign EX_DATA1       = data1_q;
    assign EX_DATA2       = data2_q;
    assign EX_IMM         = imm_q;
    assign EX_RS1         = rs1_q;
    assign EX_RS2         = rs2_q;
    assign EX_RD          = rd_q;
    assign EX_ALUOP       = aluop_q;
    assign EX_WRITEENABLE = ctrl_q.writeenable;
    assign EX_MEMREAD     = ctrl_q.memread;
    assign EX_MEMWRITE    = ctrl_q.memwrite;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: stimulus queues per-cycle field
// expectations, a negedge monitor pops and compares them.
module tb_id_ex_pipeline_reg;

    localparam int F_PC = 0, F_D1 = 1, F_D2 = 2, F_IMM = 3, F_RS1 = 4, F_RS2 = 5,
                   F_RD = 6, F_ALUOP = 7, F_WE = 8, F_MR = 9, F_MW = 10, F_STALL = 11;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] ID_PC = '0, ID_DATA1 = '0, ID_DATA2 = '0, ID_IMM = '0;
    logic [4:0]  ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
    logic [2:0]  ID_ALUOP = '0;
    logic        ID_WRITEENABLE = 1'b0, ID_MEMREAD = 1'b0, ID_MEMWRITE = 1'b0;
    logic [4:0]  WB_WRITEREG = '0;
    logic [31:0] WB_WRITEDATA = '0;
    logic        WB_WRITEENABLE = 1'b0;
    logic        FLUSH = 1'b0, MEM_BUSY = 1'b0;
    logic [31:0] EX_PC, EX_DATA1, EX_DATA2, EX_IMM;
    logic [4:0]  EX_RS1, EX_RS2, EX_RD;
    logic [2:0]  EX_ALUOP;
    logic        EX_WRITEENABLE, EX_MEMREAD, EX_MEMWRITE, HAZARD_STALL;

    id_ex_pipeline_reg dut (
        .CLK(CLK), .RESET(RESET),
        .ID_PC(ID_PC), .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2), .ID_IMM(ID_IMM),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_ALUOP(ID_ALUOP),
        .ID_WRITEENABLE(ID_WRITEENABLE), .ID_MEMREAD(ID_MEMREAD), .ID_MEMWRITE(ID_MEMWRITE),
        .WB_WRITEREG(WB_WRITEREG), .WB_WRITEDATA(WB_WRITEDATA), .WB_WRITEENABLE(WB_WRITEENABLE),
        .FLUSH(FLUSH), .MEM_BUSY(MEM_BUSY),
        .EX_PC(EX_PC), .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2), .EX_IMM(EX_IMM),
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_ALUOP(EX_ALUOP),
        .EX_WRITEENABLE(EX_WRITEENABLE), .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE),
        .HAZARD_STALL(HAZARD_STALL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        string       name;
        int          field;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] dut_field(int f);
        case (f)
            F_PC:    return EX_PC;
            F_D1:    return EX_DATA1;
            F_D2:    return EX_DATA2;
            F_IMM:   return EX_IMM;
            F_RS1:   return 32'(EX_RS1);
            F_RS2:   return 32'(EX_RS2);
            F_RD:    return 32'(EX_RD);
            F_ALUOP: return 32'(EX_ALUOP);
            F_WE:    return 32'(EX_WRITEENABLE);
            F_MR:    return 32'(EX_MEMREAD);
            F_MW:    return 32'(EX_MEMWRITE);
            default: return 32'(HAZARD_STALL);
        endcase
    endfunction

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge CLK) begin
        while (!done && sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                failures++;
                $display("FAIL %s field=%0d stale expectation cyc=%0d now=%0d", e.name, e.field, e.cyc, cyc);
            end else begin
                act = dut_field(e.field);
                if (act !== e.value) begin
                    failures++;
                    $display("FAIL %s field=%0d actual=0x%0h required=0x%0h (cyc %0d)",
                             e.name, e.field, act, e.value, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_f(int dcyc, string name, int f, logic [31:0] v);
        exp_t e;
        e.cyc = cyc + dcyc;
        e.name = name;
        e.field = f;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic exp_ex(int dcyc, string name, logic [31:0] pc, logic [31:0] d1, logic [31:0] d2,
                          logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                          logic [2:0] aluop, logic we, logic mr, logic mw);
        exp_f(dcyc, name, F_PC, pc);
        exp_f(dcyc, name, F_D1, d1);
        exp_f(dcyc, name, F_D2, d2);
        exp_f(dcyc, name, F_IMM, imm);
        exp_f(dcyc, name, F_RS1, 32'(rs1));
        exp_f(dcyc, name, F_RS2, 32'(rs2));
        exp_f(dcyc, name, F_RD, 32'(rd));
        exp_f(dcyc, name, F_ALUOP, 32'(aluop));
        exp_f(dcyc, name, F_WE, 32'(we));
        exp_f(dcyc, name, F_MR, 32'(mr));
        exp_f(dcyc, name, F_MW, 32'(mw));
    endtask

    task automatic drive_id(logic [31:0] pc, logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                            logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [2:0] aluop,
                            logic we, logic mr, logic mw);
        ID_PC = pc; ID_DATA1 = d1; ID_DATA2 = d2; ID_IMM = imm;
        ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd; ID_ALUOP = aluop;
        ID_WRITEENABLE = we; ID_MEMREAD = mr; ID_MEMWRITE = mw;
    endtask

    task automatic drive_wb(logic we, logic [4:0] r, logic [31:0] d);
        WB_WRITEENABLE = we; WB_WRITEREG = r; WB_WRITEDATA = d;
    endtask

    initial begin
        step(); step();
        RESET = 1'b0;
        exp_ex(0, "reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_f(0, "reset_stall", F_STALL, 0);

        // Plain store passes through untouched
        step();
        drive_id(32'h100, 32'h11, 32'h22, 32'h33, 5'd1, 5'd3, 5'd7, 3'd2, 1'b0, 1'b0, 1'b1);
        exp_f(0, "plain_stall", F_STALL, 0);
        exp_ex(1, "plain_load", 32'h100, 32'h11, 32'h22, 32'h33, 5'd1, 5'd3, 5'd7, 3'd2, 1'b0, 1'b0, 1'b1);

        // Writeback bypass onto rs1
        step();
        drive_id(32'h104, 32'h0, 32'h55, 32'h4, 5'd2, 5'd5, 5'd8, 3'd1, 1'b1, 1'b0, 1'b0);
        drive_wb(1'b1, 5'd2, 32'd95);
        exp_ex(1, "bypass_rs1", 32'h104, 32'd95, 32'h55, 32'h4, 5'd2, 5'd5, 5'd8, 3'd1, 1'b1, 1'b0, 1'b0);

        // x0 is never bypassed
        step();
        drive_id(32'h108, 32'h10, 32'h0, 32'h8, 5'd0, 5'd0, 5'd9, 3'd3, 1'b1, 1'b0, 1'b0);
        drive_wb(1'b1, 5'd0, 32'd28);
        exp_ex(1, "no_bypass_x0", 32'h108, 32'h10, 32'h0, 32'h8, 5'd0, 5'd0, 5'd9, 3'd3, 1'b1, 1'b0, 1'b0);

        // Mid-cycle reset clears EX immediately
        step();
        drive_wb(1'b0, 5'd0, 32'd0);
        step();
        RESET = 1'b1;
        exp_ex(0, "async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_f(0, "reset_stall_low", F_STALL, 0);
        step();
        RESET = 1'b0;
        drive_id(32'h10C, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 3'd4, 1'b1, 1'b0, 1'b0);
        exp_f(0, "held_in_reset", F_PC, 0);
        exp_ex(1, "post_reset_load", 32'h10C, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 3'd4, 1'b1, 1'b0, 1'b0);

        // Load-use on rs2: one stall cycle, one bubble
        step();
        drive_id(32'h200, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd4, 3'd0, 1'b1, 1'b1, 1'b0);
        exp_ex(1, "load_issue", 32'h200, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd4, 3'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive_id(32'h204, 32'h66, 32'h77, 32'h88, 5'd6, 5'd4, 5'd9, 3'd3, 1'b1, 1'b0, 1'b0);
        exp_f(0, "load_use_stall", F_STALL, 1);
        exp_ex(1, "load_use_bubble", 32'h204, 32'h66, 32'h77, 32'h88, 5'd6, 5'd4, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        exp_f(0, "stall_one_cycle", F_STALL, 0);
        exp_ex(1, "after_stall", 32'h204, 32'h66, 32'h77, 32'h88, 5'd6, 5'd4, 5'd9, 3'd3, 1'b1, 1'b0, 1'b0);

        // Flush during busy: hold for 3 cycles, then bubble
        step();
        drive_id(32'h300, 32'h1, 32'h2, 32'h3, 5'd6, 5'd7, 5'd10, 3'd4, 1'b1, 1'b0, 1'b0);
        FLUSH = 1'b1; MEM_BUSY = 1'b1;
        exp_f(0, "busy_stall", F_STALL, 0);
        exp_ex(1, "busy_hold1", 32'h204, 32'h66, 32'h77, 32'h88, 5'd6, 5'd4, 5'd9, 3'd3, 1'b1, 1'b0, 1'b0);
        step();
        FLUSH = 1'b0;
        drive_id(32'h304, 32'h1, 32'h2, 32'h3, 5'd6, 5'd7, 5'd11, 3'd4, 1'b1, 1'b0, 1'b0);
        drive_wb(1'b1, 5'd6, 32'hDEAD);
        exp_ex(1, "busy_hold2", 32'h204, 32'h66, 32'h77, 32'h88, 5'd6, 5'd4, 5'd9, 3'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive_wb(1'b0, 5'd0, 32'd0);
        exp_ex(1, "busy_hold3", 32'h204, 32'h66, 32'h77, 32'h88, 5'd6, 5'd4, 5'd9, 3'd3, 1'b1, 1'b0, 1'b0);
        step();
        MEM_BUSY = 1'b0;
        drive_id(32'h308, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd12, 3'd5, 1'b1, 1'b0, 1'b0);
        exp_ex(1, "pending_bubble", 32'h308, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_id(32'h30C, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd13, 3'd5, 1'b1, 1'b0, 1'b0);
        exp_ex(1, "pending_cleared", 32'h30C, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd13, 3'd5, 1'b1, 1'b0, 1'b0);

        // Load-use coinciding with flush: no stall, single bubble
        step();
        drive_id(32'h400, 32'h1, 32'h2, 32'h3, 5'd0, 5'd0, 5'd5, 3'd0, 1'b1, 1'b1, 1'b0);
        exp_f(1, "load2_rd", F_RD, 32'd5);
        exp_f(1, "load2_mr", F_MR, 32'd1);
        step();
        drive_id(32'h404, 32'h1, 32'h2, 32'h3, 5'd5, 5'd0, 5'd14, 3'd2, 1'b1, 1'b0, 1'b0);
        FLUSH = 1'b1;
        exp_f(0, "flush_masks_stall", F_STALL, 0);
        exp_ex(1, "flush_bubble", 32'h404, 32'h1, 32'h2, 32'h3, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        FLUSH = 1'b0;
        drive_id(32'h408, 32'h9, 32'h2, 32'h3, 5'd5, 5'd0, 5'd15, 3'd1, 1'b1, 1'b0, 1'b0);
        exp_f(0, "no_extra_stall", F_STALL, 0);
        exp_ex(1, "after_flush", 32'h408, 32'h9, 32'h2, 32'h3, 5'd5, 5'd0, 5'd15, 3'd1, 1'b1, 1'b0, 1'b0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        step();
        done = 1'b1;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
